instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Multicycle fetch stage that sits directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM word address.
- After a configurable settle delay, samples the ROM output into an instruction register and advances the PC.
- Applies control-unit redirects (branch, jump, jr), and flags any PC outside the ROM window or not word-aligned.

Parameters:
- DATA_WIDTH, 32, width of PC, address and instruction.
- RESET_PC, 32'h0040_0000, PC after reset; base of the ROM window.
- ROM_WORDS, 64, number of instruction words in the ROM window.
- ROM_WAIT, 1, clock cycles (≥1) between a stable rom_addr and sampling rom_q.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- fetch_req  input  1  control unit requests one instruction fetch.
- pc_load  input  1  single-cycle redirect strobe; effective in IDLE or FAULT only.
- pc_src  input  2  redirect source: 00 PC+4, 01 branch, 10 jump, 11 register.
- branch_offset  input  16  signed word offset for a branch.
- jump_index  input  26  J-type index field.
- reg_target  input  DATA_WIDTH  jr target address.
- rom_addr  output  DATA_WIDTH  byte address presented to the ROM; always equals pc.
- rom_q  input  DATA_WIDTH  ROM data.
- pc  output  DATA_WIDTH  current PC.
- instr  output  DATA_WIDTH  instruction register.
- instr_valid  output  1  one-cycle pulse when instr is updated.
- busy  output  1  high in WAIT and LATCH.
- addr_fault  output  1  high while in FAULT.

Behaviour:
- Reset (asynchronous, immediate, including mid-fetch):
  - pc=RESET_PC, instr=0, instr_valid=0, busy=0, addr_fault=0.
  - State returns to IDLE; wait counter cleared.
- Legal PC: RESET_PC ≤ pc < RESET_PC+4*ROM_WORDS and pc[1:0]==0. All compares are unsigned, 32-bit.
- States: IDLE, WAIT, LATCH, FAULT.
- IDLE:
  - pc_load=1: load pc from the target selected by pc_src; stay IDLE. pc_load has priority over a simultaneous fetch_req, and that fetch_req is dropped.
  - Else fetch_req=1 with an illegal pc: go to FAULT.
  - Else fetch_req=1 with a legal pc: load counter with ROM_WAIT-1, go to WAIT.
- WAIT: decrement the counter; when it is 0, go to LATCH. fetch_req and pc_load are ignored.
- LATCH:
  - instr<=rom_q, pc<=pc+4 (32-bit wrap), instr_valid=1 for exactly this one edge-to-edge cycle.
  - Return to IDLE.
  - Latency: fetch_req sampled at edge N gives instr valid after edge N+ROM_WAIT+1.
- FAULT:
  - addr_fault=1, instr holds its value, fetch_req is ignored.
  - Only pc_load (to any target) or reset leaves FAULT: pc is loaded, next state is IDLE. The new pc is rechecked on the next fetch_req.
- Redirect targets are computed from the current pc, which is already the fetched instruction's address + 4:
  - 00: pc+4.
  - 01: pc + (sign-extended branch_offset << 2).
  - 10: {pc[31:28], jump_index, 2'b00}.
  - 11: reg_target (alignment checked at the next fetch, not at load).
- Back-to-back fetch: a fetch_req asserted during LATCH is ignored; it must still be high in IDLE to be accepted. Maximum throughput is one instruction per ROM_WAIT+2 cycles.
- rom_addr is combinational from pc and stays stable throughout WAIT and LATCH.

Test Plan:
- Reset then fetch_req (ROM_WAIT=1, rom_q=32'h2008_0005 at 0x0040_0000):
  - instr=32'h2008_0005 with one instr_valid pulse, 2 cycles after the request edge.
  - pc=0x0040_0004; busy high for exactly 2 cycles.
- Branch: at pc=0x0040_0008, pc_load with pc_src=01 and branch_offset=16'hFFFE -> pc=0x0040_0000. Next fetch returns word 0.
- Jump and jr:
  - pc_src=10, jump_index=26'h010_0003 -> pc=0x0040_000C.
  - pc_src=11, reg_target=0x0040_0012, then fetch_req -> FAULT with addr_fault=1; a further fetch_req is ignored.
  - pc_load with reg_target=0x0040_0010 -> clears the fault; the next fetch succeeds.
- Window boundary (ROM_WORDS=64):
  - Fetch at pc=0x0040_00FC succeeds, pc=0x0040_0100.
  - Next fetch_req -> FAULT; instr keeps the last word.
- Simultaneous events:
  - pc_load and fetch_req together in IDLE -> pc redirected, no fetch.
  - pc_load during WAIT -> ignored; the fetch completes and pc = old pc+4.
- Reset asserted in WAIT with ROM_WAIT=3 -> outputs return to reset values immediately, with no instr_valid pulse. The next fetch reads 0x0040_0000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch stage: owns the PC, addresses the instruction ROM,
// latches rom_q after a settle delay, applies redirects and flags illegal fetch addresses.
module instr_fetch_unit #(
    parameter int unsigned                 DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]       RESET_PC   = DATA_WIDTH'(32'h0040_0000),
    parameter int unsigned                 ROM_WORDS  = 64,
    parameter int unsigned                 ROM_WAIT   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic                  pc_load,
    input  logic [1:0]            pc_src,
    input  logic [15:0]           branch_offset,
    input  logic [25:0]           jump_index,
    input  logic [DATA_WIDTH-1:0] reg_target,
    output logic [DATA_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    output logic                  busy,
    output logic                  addr_fault
);

    localparam int unsigned CNT_W = (ROM_WAIT > 1) ? $clog2(ROM_WAIT) : 1;
    localparam logic [DATA_WIDTH-1:0] ROM_END = RESET_PC + DATA_WIDTH'(4 * ROM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_LATCH = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t                  state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [DATA_WIDTH-1:0]   pc_n, instr_n, redirect;
    logic                    valid_n, busy_n, fault_n, pc_legal;

    assign rom_addr = pc;
    assign pc_legal = (pc >= RESET_PC) && (pc < ROM_END) && (pc[1:0] == 2'b00);

    // Redirect target relative to the current pc (already fetched address + 4)
    always_comb begin
        redirect = pc + DATA_WIDTH'(4);
        case (pc_src)
            2'b00:   redirect = pc + DATA_WIDTH'(4);
            2'b01:   redirect = pc + {{(DATA_WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};
            2'b10:   redirect = {pc[DATA_WIDTH-1:28], jump_index, 2'b00};
            default: redirect = reg_target;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pc_n    = pc;
        instr_n = instr;
        valid_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (pc_load) begin
                    pc_n = redirect;
                end else if (fetch_req) begin
                    if (!pc_legal) begin
                        state_n = S_FAULT;
                    end else begin
                        cnt_n   = CNT_W'(ROM_WAIT - 1);
                        state_n = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) state_n = S_LATCH;
                else           cnt_n   = cnt - CNT_W'(1);
            end
            S_LATCH: begin
                instr_n = rom_q;
                pc_n    = pc + DATA_WIDTH'(4);
                valid_n = 1'b1;
                state_n = S_IDLE;
            end
            S_FAULT: begin
                if (pc_load) begin
                    pc_n    = redirect;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        busy_n  = (state_n == S_WAIT) || (state_n == S_LATCH);
        fault_n = (state_n == S_FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            addr_fault  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            pc          <= pc_n;
            instr       <= instr_n;
            instr_valid <= valid_n;
            busy        <= busy_n;
            addr_fault  <= fault_n;
        end
    end

endmodule
